// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the RISC-V datapath (lw, sw, add/sub, beq/bne, jal, jalr, auipc).
// Optional retired-instruction counter enabled by defining CONTADOR_INSTR_EN.
module unidade_controle_multiciclo #(
   parameter int CICLOS_MEMORIA   = 1,
   parameter int LARGURA_CONTADOR = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        zero,
   output logic        carrega_instr,
   output logic        we_reg,
   output logic        we_mem,
   output logic        soma_ou_subtrai,
   output logic        subtraindo,
   output logic        imediato,
   output logic [2:0]  sel_imediato,
   output logic [1:0]  sel_din_reg,
   output logic        atualiza_pc,
   output logic [1:0]  sel_pc,
   output logic [2:0]  estado,
   output logic        erro
`ifdef CONTADOR_INSTR_EN
   ,
   output logic [LARGURA_CONTADOR-1:0] instr_concluidas
`endif
);

   typedef enum logic [2:0] {
      BUSCA      = 3'd0,
      DECODIFICA = 3'd1,
      EXECUTA    = 3'd2,
      MEMORIA    = 3'd3,
      ESCRITA    = 3'd4,
      ERRO       = 3'd5
   } estado_t;

   typedef enum logic [2:0] {
      CL_LW, CL_SW, CL_R, CL_BR, CL_JAL, CL_JALR, CL_AUIPC, CL_ILEGAL
   } classe_t;

   localparam int CW = (CICLOS_MEMORIA > 1) ? $clog2(CICLOS_MEMORIA) : 1;
   localparam logic [CW-1:0] CARGA_MEM = CW'(CICLOS_MEMORIA - 1);

   estado_t       estado_q, estado_d;
   logic [CW-1:0] contador_q, contador_d;
   classe_t       classe;
   logic          rd_nz;
   logic          desvio;

   always_comb begin
      classe = CL_ILEGAL;
      case (instr[6:0])
         7'b0000011: classe = CL_LW;
         7'b0100011: classe = CL_SW;
         7'b1101111: classe = CL_JAL;
         7'b0010111: classe = CL_AUIPC;
         7'b0110011:
            if (instr[14:12] == 3'b000 &&
                (instr[31:25] == 7'b0000000 || instr[31:25] == 7'b0100000))
               classe = CL_R;
         7'b1100011:
            if (instr[14:13] == 2'b00)
               classe = CL_BR;
         7'b1100111:
            if (instr[14:12] == 3'b000)
               classe = CL_JALR;
         default: classe = CL_ILEGAL;
      endcase
   end

   assign rd_nz  = |instr[11:7];
   // funct3 bit 0 distinguishes bne from beq
   assign desvio = instr[12] ? ~zero : zero;

   always_comb begin
      estado_d        = estado_q;
      contador_d      = contador_q;
      carrega_instr   = 1'b0;
      we_reg          = 1'b0;
      we_mem          = 1'b0;
      soma_ou_subtrai = 1'b0;
      subtraindo      = 1'b0;
      imediato        = 1'b0;
      sel_imediato    = 3'd0;
      sel_din_reg     = 2'd0;
      atualiza_pc     = 1'b0;
      sel_pc          = 2'd0;
      erro            = 1'b0;
      case (estado_q)
         BUSCA: begin
            carrega_instr = 1'b1;
            estado_d      = DECODIFICA;
         end
         DECODIFICA: estado_d = (classe == CL_ILEGAL) ? ERRO : EXECUTA;
         EXECUTA: begin
            case (classe)
               CL_LW, CL_SW: begin
                  soma_ou_subtrai = 1'b1;
                  imediato        = 1'b1;
                  sel_imediato    = (classe == CL_SW) ? 3'd1 : 3'd0;
                  contador_d      = CARGA_MEM;
                  estado_d        = MEMORIA;
               end
               CL_R: begin
                  soma_ou_subtrai = 1'b1;
                  subtraindo      = instr[30];
                  estado_d        = ESCRITA;
               end
               CL_BR: begin
                  soma_ou_subtrai = 1'b1;
                  subtraindo      = 1'b1;
                  sel_imediato    = 3'd2;
                  atualiza_pc     = 1'b1;
                  sel_pc          = desvio ? 2'd1 : 2'd0;
                  estado_d        = BUSCA;
               end
               CL_JAL: begin
                  we_reg       = rd_nz;
                  sel_din_reg  = 2'd2;
                  sel_imediato = 3'd3;
                  atualiza_pc  = 1'b1;
                  sel_pc       = 2'd1;
                  estado_d     = BUSCA;
               end
               CL_JALR: begin
                  soma_ou_subtrai = 1'b1;
                  imediato        = 1'b1;
                  estado_d        = ESCRITA;
               end
               CL_AUIPC: begin
                  we_reg       = rd_nz;
                  sel_din_reg  = 2'd3;
                  sel_imediato = 3'd4;
                  atualiza_pc  = 1'b1;
                  estado_d     = BUSCA;
               end
               default: estado_d = ERRO;
            endcase
         end
         MEMORIA: begin
            // address operands stay on the ULA while memory is busy
            soma_ou_subtrai = 1'b1;
            imediato        = 1'b1;
            sel_imediato    = (classe == CL_SW) ? 3'd1 : 3'd0;
            if (contador_q == '0) begin
               if (classe == CL_SW) begin
                  we_mem      = 1'b1;
                  atualiza_pc = 1'b1;
                  estado_d    = BUSCA;
               end else begin
                  estado_d = ESCRITA;
               end
            end else begin
               contador_d = contador_q - 1'b1;
            end
         end
         ESCRITA: begin
            estado_d = BUSCA;
            case (classe)
               CL_LW: begin
                  we_reg          = rd_nz;
                  sel_din_reg     = 2'd1;
                  soma_ou_subtrai = 1'b1;
                  imediato        = 1'b1;
                  atualiza_pc     = 1'b1;
               end
               CL_R: begin
                  we_reg          = rd_nz;
                  soma_ou_subtrai = 1'b1;
                  subtraindo      = instr[30];
                  atualiza_pc     = 1'b1;
               end
               CL_JALR: begin
                  we_reg          = rd_nz;
                  sel_din_reg     = 2'd2;
                  soma_ou_subtrai = 1'b1;
                  imediato        = 1'b1;
                  atualiza_pc     = 1'b1;
                  sel_pc          = 2'd2;
               end
               default: estado_d = BUSCA;
            endcase
         end
         ERRO: begin
            erro     = 1'b1;
            estado_d = ERRO;
         end
         default: estado_d = BUSCA;
      endcase
      // a cycle in which reset is sampled must not enable anything
      if (reset) begin
         carrega_instr   = 1'b0;
         we_reg          = 1'b0;
         we_mem          = 1'b0;
         soma_ou_subtrai = 1'b0;
         subtraindo      = 1'b0;
         imediato        = 1'b0;
         sel_imediato    = 3'd0;
         sel_din_reg     = 2'd0;
         atualiza_pc     = 1'b0;
         sel_pc          = 2'd0;
         erro            = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q   <= BUSCA;
         contador_q <= '0;
      end else begin
         estado_q   <= estado_d;
         contador_q <= contador_d;
      end
   end

   assign estado = reset ? 3'd0 : estado_q;

`ifdef CONTADOR_INSTR_EN
   logic [LARGURA_CONTADOR-1:0] instr_concluidas_q, instr_concluidas_d;

   always_comb begin
      instr_concluidas_d = instr_concluidas_q;
      if (atualiza_pc)
         instr_concluidas_d = instr_concluidas_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         instr_concluidas_q <= '0;
      else
         instr_concluidas_q <= instr_concluidas_d;
   end

   assign instr_concluidas = instr_concluidas_q;

   logic unused_ok;
   assign unused_ok = ^instr[24:15];
`else
   logic unused_ok;
   assign unused_ok = ^{instr[24:15], LARGURA_CONTADOR[0]};
`endif

endmodule
